// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the device with the host-request handshake:
// inhibit the clock, pull data low as the start bit, then shift the data
// bits, odd parity and stop bit out on device clock falling edges. The
// device ACK is sampled on the 11th edge. The PS/2 lines are open-drain,
// so each one is modelled as a raw input level plus a drive-low enable.
// The lines are oversampled in the system clock domain and are never
// used as clocks.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       send,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic       timeout
);

  localparam int InhW = $clog2(INHIBIT_CYCLES + 1);
  localparam int ToW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [InhW-1:0] InhLoad = InhW'(INHIBIT_CYCLES);
  localparam logic [InhW-1:0] InhOne  = InhW'(1);
  localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [ToW-1:0]  ToOne   = ToW'(1);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    XMIT,
    RELEASE
  } state_t;

  state_t          state_q;
  logic [InhW-1:0] inhCnt_q;
  logic [ToW-1:0]  toCnt_q;
  logic [3:0]      edgeCnt_q;
  logic [3:0]      edgeCnt_d;
  logic [8:0]      frame_q;
  logic            clkOe_q;
  logic            dataOe_q;
  logic            busy_q;
  logic            done_q;
  logic            ackErr_q;
  logic            tmo_q;

  logic [1:0]      clkSync_q;
  logic [1:0]      dataSync_q;
  logic            clkPrev_q;
  logic            clkSynced;
  logic            dataSynced;
  logic            fallEdge;

  // Two-flop synchronisers for both lines plus a delayed copy of the synced
  // clock for falling-edge detection; idle lines read as 1 after reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
      clkPrev_q  <= 1'b1;
    end else begin
      clkSync_q  <= {clkSync_q[0], ps2_clk_in};
      dataSync_q <= {dataSync_q[0], ps2_data_in};
      clkPrev_q  <= clkSync_q[1];
    end
  end

  assign clkSynced  = clkSync_q[1];
  assign dataSynced = dataSync_q[1];
  assign fallEdge   = clkPrev_q & ~clkSynced;
  assign edgeCnt_d  = edgeCnt_q + 4'd1;

  // Transfer sequencer: every line enable and status flag is a register so
  // the pins never glitch; enable changes land one clock after the edge
  // strobe, which is far inside the device's half-period.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q   <= IDLE;
      inhCnt_q  <= '0;
      toCnt_q   <= '0;
      edgeCnt_q <= '0;
      frame_q   <= '0;
      clkOe_q   <= 1'b0;
      dataOe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ackErr_q  <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          clkOe_q  <= 1'b0;
          dataOe_q <= 1'b0;
          if (send && !done_q) begin
            frame_q  <= {~^tx_data, tx_data};
            ackErr_q <= 1'b0;
            tmo_q    <= 1'b0;
            inhCnt_q <= InhLoad;
            busy_q   <= 1'b1;
            clkOe_q  <= 1'b1;
            state_q  <= INHIBIT;
          end
        end

        INHIBIT: begin
          if (inhCnt_q == InhOne) begin
            inhCnt_q <= '0;
            dataOe_q <= 1'b1;
            state_q  <= REQUEST;
          end else begin
            inhCnt_q <= inhCnt_q - InhOne;
          end
        end

        REQUEST: begin
          clkOe_q   <= 1'b0;
          edgeCnt_q <= '0;
          toCnt_q   <= '0;
          state_q   <= XMIT;
        end

        XMIT: begin
          if (fallEdge) begin
            toCnt_q   <= '0;
            edgeCnt_q <= edgeCnt_d;
            if (edgeCnt_d == 4'd11) begin
              ackErr_q <= dataSynced;
              state_q  <= RELEASE;
            end else begin
              dataOe_q <= ~frame_q[0];
              frame_q  <= {1'b1, frame_q[8:1]};
            end
          end else if (toCnt_q == ToLast) begin
            clkOe_q   <= 1'b0;
            dataOe_q  <= 1'b0;
            tmo_q     <= 1'b1;
            ackErr_q  <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            toCnt_q   <= '0;
            edgeCnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            toCnt_q <= toCnt_q + ToOne;
          end
        end

        RELEASE: begin
          if (clkSynced && dataSynced) begin
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            toCnt_q   <= '0;
            edgeCnt_q <= '0;
            state_q   <= IDLE;
          end else if (toCnt_q == ToLast) begin
            clkOe_q   <= 1'b0;
            dataOe_q  <= 1'b0;
            tmo_q     <= 1'b1;
            ackErr_q  <= 1'b1;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            toCnt_q   <= '0;
            edgeCnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            toCnt_q <= toCnt_q + ToOne;
          end
        end

        default: begin
          clkOe_q  <= 1'b0;
          dataOe_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe  = clkOe_q;
  assign ps2_data_oe = dataOe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_error   = ackErr_q;
  assign timeout     = tmo_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host,
// a scoreboard queue holds the expected result of each accepted send, and a
// monitor checks every done pulse against it.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 400;
  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       send = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       devClk = 1'b1;
  logic       devData = 1'b1;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       busy;
  logic       done;
  logic       ack_error;
  logic       timeout;

  int checks = 0;
  int fails = 0;
  int cycleCnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       expAck;
    logic       expTmo;
    logic       checkFrame;
  } exp_t;

  exp_t       expQ[$];
  logic [9:0] rxQ[$];

  logic       cfgAck = 1'b1;
  int         cfgFeLimit = 11;
  int         modelFe = 0;
  bit         modelIdle = 1'b1;
  int         lastFallCycle = 0;
  logic [9:0] modelBits = '0;

  // Open-drain wiring: a line reads low if either side pulls it low.
  assign ps2_clk_in  = devClk & ~ps2_clk_oe;
  assign ps2_data_in = devData & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .send       (send),
    .tx_data    (tx_data),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_error  (ack_error),
    .timeout    (timeout)
  );

  // Free-running system clock.
  always #5 clock = ~clock;

  // Cycle counter used for latency measurement.
  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic refParity(input logic [7:0] d);
    return ($countones(d) % 2 == 0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Device model: once the host releases the clock with data held low, it
  // generates up to cfgFeLimit clock pulses, samples data on each rising
  // edge, and optionally ACKs by pulling data low around the 11th edge.
  initial begin : deviceModel
    int guard;
    forever begin
      @(negedge clock);
      if (resetn && !ps2_clk_oe && ps2_data_oe) begin
        modelIdle = 1'b0;
        modelFe = 0;
        repeat (10) @(negedge clock);
        for (int k = 1; k <= cfgFeLimit; k++) begin
          if (k == 11 && cfgAck) begin
            devData = 1'b0;
            repeat (5) @(negedge clock);
          end
          devClk = 1'b0;
          modelFe = k;
          lastFallCycle = cycleCnt;
          repeat (HALF) @(negedge clock);
          devClk = 1'b1;
          if (k <= 10) modelBits[k-1] = ps2_data_in;
          if (k == 10 && cfgFeLimit >= 11) rxQ.push_back(modelBits);
          if (k == 11) begin
            repeat (5) @(negedge clock);
            devData = 1'b1;
            repeat (HALF - 5) @(negedge clock);
          end else begin
            repeat (HALF) @(negedge clock);
          end
        end
        guard = 0;
        while ((ps2_clk_oe || ps2_data_oe) && guard < 2000) begin
          @(negedge clock);
          guard++;
        end
        devClk = 1'b1;
        devData = 1'b1;
        modelFe = 0;
        modelIdle = 1'b1;
      end
    end
  end

  // Monitor: on every done pulse pop the expected result and compare flags,
  // the frame the device captured, and the timeout latency where relevant.
  initial begin : monitor
    bit         prevDone;
    exp_t       e;
    logic [9:0] f;
    int         lat;
    prevDone = 1'b0;
    forever begin
      @(negedge clock);
      if (prevDone) checkOutput("done one cycle", done, 0);
      if (resetn && done) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected done", 1, 0);
        end else begin
          e = expQ.pop_front();
          checkOutput("ack_error at done", ack_error, e.expAck);
          checkOutput("timeout at done", timeout, e.expTmo);
          checkOutput("busy at done", busy, 0);
          if (e.checkFrame) begin
            if (rxQ.size() == 0) begin
              checkOutput("frame received", 0, 1);
            end else begin
              f = rxQ.pop_front();
              checkOutput("frame data", f[7:0], e.data);
              checkOutput("frame parity", f[8], refParity(e.data));
              checkOutput("frame stop", f[9], 1);
            end
          end
          if (e.expTmo) begin
            lat = cycleCnt - lastFallCycle;
            checkOutput("timeout latency", lat, (lat >= TMO && lat <= TMO + 10) ? lat : TMO);
            checkOutput("lines released at timeout", {ps2_clk_oe, ps2_data_oe}, 0);
          end
        end
      end
      prevDone = done;
    end
  end

  // Issue one send; queue the expected outcome; optionally check inhibit and
  // request timing, and pulse send again mid-transfer.
  task automatic applyStimulus(input logic [7:0] data, input logic ack, input int feLimit,
                               input bit expectDone, input bit checkTiming, input bit midPulse);
    int   guard;
    int   cnt;
    exp_t e;
    guard = 0;
    while ((busy || !modelIdle) && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 5000) checkOutput("idle wait expired", 0, 1);
    cfgAck = ack;
    cfgFeLimit = feLimit;
    repeat (3) @(negedge clock);
    tx_data = data;
    send = 1'b1;
    if (expectDone) begin
      e.data = data;
      e.expTmo = (feLimit < 11);
      e.expAck = (feLimit < 11) || !ack;
      e.checkFrame = (feLimit >= 11);
      expQ.push_back(e);
    end
    @(negedge clock);
    send = 1'b0;
    tx_data = 8'($urandom);
    checkOutput("busy after accept", busy, 1);
    checkOutput("flags cleared on accept", {ack_error, timeout}, 0);
    if (checkTiming) begin
      cnt = 0;
      while (ps2_clk_oe && !ps2_data_oe && cnt < 100) begin
        cnt++;
        @(negedge clock);
      end
      checkOutput("inhibit length", cnt, INH);
      checkOutput("request oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
      @(negedge clock);
      checkOutput("start bit oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    end
    if (midPulse) begin
      repeat (150) @(negedge clock);
      tx_data = ~data;
      send = 1'b1;
      @(negedge clock);
      send = 1'b0;
    end
    if (expectDone) begin
      guard = 0;
      while (expQ.size() != 0 && guard < 3000) begin
        @(negedge clock);
        guard++;
      end
      if (guard >= 3000) checkOutput("done wait expired", 0, 1);
    end
  endtask

  initial begin : stimulus
    int guard;
    // Reset with random inputs.
    resetn = 1'b0;
    repeat (2) begin
      @(negedge clock);
      send = 1'($urandom);
      tx_data = 8'($urandom);
    end
    @(negedge clock);
    checkOutput("reset clk_oe", ps2_clk_oe, 0);
    checkOutput("reset data_oe", ps2_data_oe, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset ack_error", ack_error, 0);
    checkOutput("reset timeout", timeout, 0);
    send = 1'b0;
    resetn = 1'b1;

    applyStimulus(8'hED, 1'b1, 11, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h00, 1'b1, 11, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h07, 1'b1, 11, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hFF, 1'b0, 11, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'($urandom), 1'b1, 5, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hF4, 1'b1, 11, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'($urandom), 1'b1, 11, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'($urandom), 1'($urandom_range(0, 1)), 11, 1'b1, 1'b0, 1'b0);
    end

    // Reset in the middle of the bit phase: lines drop on that edge, no done.
    applyStimulus(8'h5A, 1'b1, 6, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (modelFe < 3 && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 2000) checkOutput("mid-transfer wait expired", 0, 1);
    resetn = 1'b0;
    @(negedge clock);
    checkOutput("reset mid-xmit oe", {ps2_clk_oe, ps2_data_oe}, 0);
    checkOutput("reset mid-xmit busy", busy, 0);
    checkOutput("reset mid-xmit done", done, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    applyStimulus(8'h01, 1'b1, 11, 1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge clock);
    checkOutput("scoreboard drained", expQ.size(), 0);
    checkOutput("idle after test", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
